// File: rtl/rca16_multiword_seq.sv
// Wide add/subtract sequencer: one shared 16-bit ripple-carry adder handles one
// slice per clock, LSB slice first. The carry is held in a register between slices.
module RippleCarryAdder16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  logic [16:0] carry_s;
  logic [1:0]  fa_s;

  // Bit-serial carry ripple through sixteen full adders.
  always_comb begin
    carry_s    = 17'd0;
    sum_o      = 16'd0;
    fa_s       = 2'd0;
    carry_s[0] = cin_i;
    for (int i = 0; i < 16; i++) begin
      fa_s           = full_add(a_i[i], b_i[i], carry_s[i]);
      sum_o[i]       = fa_s[0];
      carry_s[i + 1] = fa_s[1];
    end
  end

  assign cout_o = carry_s[16];
endmodule

module rca16_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [16*WORDS-1:0] A,
  input  logic [16*WORDS-1:0] B,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                overflow
);
  localparam int W     = 16 * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             carry_q;
  logic             sub_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic [15:0]      a_slice_s;
  logic [15:0]      b_slice_s;
  logic [15:0]      slice_sum_s;
  logic             slice_cout_s;
  logic             slice_ovf_s;
  logic             last_s;

  assign a_slice_s = a_q[{idx_q, 4'd0} +: 16];
  assign b_slice_s = b_q[{idx_q, 4'd0} +: 16] ^ {16{sub_q}};
  assign idx_d     = idx_q + IDX_W'(1);
  assign last_s    = (idx_q == IDX_W'(WORDS - 1));

  RippleCarryAdder16 u_adder (
    .a_i    (a_slice_s),
    .b_i    (b_slice_s),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_s),
    .cout_o (slice_cout_s)
  );

  // Carry into bit 15 is recovered from the sum bit, so the adder needs no extra tap.
  assign slice_ovf_s = a_slice_s[15] ^ b_slice_s[15] ^ slice_sum_s[15] ^ slice_cout_s;

  // Sequencer FSM with all datapath and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            sub_q   <= sub;
            carry_q <= sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          sum_q[{idx_q, 4'd0} +: 16] <= slice_sum_s;
          carry_q <= slice_cout_s;
          idx_q   <= idx_d;
          if (last_s) begin
            cout_q  <= slice_cout_s;
            ovf_q   <= slice_ovf_s;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule
